// File: rtl/tt_um_emern_det_setup_pkg.sv
// rtl/tt_um_emern_det_setup_pkg.sv - shared screen constants, widths and FSM encoding for triangle setup
package tt_um_emern_det_setup_pkg;

  localparam int SCREEN_W = 64;
  localparam int SCREEN_H = 48;
  localparam int COORD_W  = 6;
  localparam int DET_W    = 13;
  localparam int DIFF_W   = COORD_W + 1;
  localparam int PROD_W   = 2 * DIFF_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIFF = 3'd1,
    ST_MUL0 = 3'd2,
    ST_MUL1 = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Zero-extend both coordinates so the difference is a true signed value in -63..63.
  function automatic logic [DIFF_W-1:0] coord_diff(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    coord_diff = {1'b0, a} - {1'b0, b};
  endfunction

endpackage

// File: rtl/tt_um_emern_smul7.sv
// rtl/tt_um_emern_smul7.sv - combinational 7x7 signed multiplier with 14-bit product
module tt_um_emern_smul7
  import tt_um_emern_det_setup_pkg::*;
(
  input  logic [DIFF_W-1:0] a,
  input  logic [DIFF_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;

  // Low 14 bits of the sign-extended product equal the signed product.
  assign a_ext = {{(PROD_W-DIFF_W){a[DIFF_W-1]}}, a};
  assign b_ext = {{(PROD_W-DIFF_W){b[DIFF_W-1]}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/tt_um_emern_det_setup.sv
// rtl/tt_um_emern_det_setup.sv - sequential edge-function determinant with one shared multiplier
module tt_um_emern_det_setup
  import tt_um_emern_det_setup_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] y2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DET_W-1:0]   determinant,
  output logic               degenerate
);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x0_q, x1_q, x2_q, y0_q, y1_q, y2_q;
  logic [COORD_W-1:0]  x0_d, x1_d, x2_d, y0_d, y1_d, y2_d;
  logic [DIFF_W-1:0]   dx1_q, dy2_q, dx2_q, dy1_q;
  logic [DIFF_W-1:0]   dx1_d, dy2_d, dx2_d, dy1_d;
  logic [PROD_W-1:0]   p0_q, p0_d;
  logic [DET_W-1:0]    det_q, det_d;
  logic                degen_q, degen_d;
  logic                out_valid_q, out_valid_d;

  logic [DIFF_W-1:0]   mul_a, mul_b;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W-1:0]   det_full;

  always_comb begin
    mul_a = dx1_q;
    mul_b = dy2_q;
    if (state_q == ST_MUL1) begin
      mul_a = dx2_q;
      mul_b = dy1_q;
    end
  end

  tt_um_emern_smul7 u_smul7 (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // Bit 13 always matches bit 12 for 6-bit inputs, so truncation is lossless.
  assign det_full = p0_q - prod;

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    dx1_d       = dx1_q;
    dy2_d       = dy2_q;
    dx2_d       = dx2_q;
    dy1_d       = dy1_q;
    p0_d        = p0_q;
    det_d       = det_q;
    degen_d     = degen_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x0_d    = x0;
          x1_d    = x1;
          x2_d    = x2;
          y0_d    = y0;
          y1_d    = y1;
          y2_d    = y2;
          state_d = ST_DIFF;
        end
      end
      ST_DIFF: begin
        dx1_d   = coord_diff(x1_q, x0_q);
        dy2_d   = coord_diff(y2_q, y0_q);
        dx2_d   = coord_diff(x2_q, x0_q);
        dy1_d   = coord_diff(y1_q, y0_q);
        state_d = ST_MUL0;
      end
      ST_MUL0: begin
        p0_d    = prod;
        state_d = ST_MUL1;
      end
      ST_MUL1: begin
        det_d       = det_full[DET_W-1:0];
        degen_d     = (det_full == '0);
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      dx1_q       <= '0;
      dy2_q       <= '0;
      dx2_q       <= '0;
      dy1_q       <= '0;
      p0_q        <= '0;
      det_q       <= '0;
      degen_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      dx1_q       <= dx1_d;
      dy2_q       <= dy2_d;
      dx2_q       <= dx2_d;
      dy1_q       <= dy1_d;
      p0_q        <= p0_d;
      det_q       <= det_d;
      degen_q     <= degen_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = out_valid_q;
  assign determinant = det_q;
  assign degenerate  = degen_q;

endmodule

// File: tb/tb_tt_um_emern_det_setup.sv
// tb/tb_tt_um_emern_det_setup.sv - randomized self-checking bench for the determinant setup stage
module tb_tt_um_emern_det_setup;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  x0, x1, x2, y0, y1, y2;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] determinant;
  logic        degenerate;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_um_emern_det_setup dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x0          (x0),
    .x1          (x1),
    .x2          (x2),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .determinant (determinant),
    .degenerate  (degenerate)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_det(input int ax0, input int ay0, input int ax1,
                                 input int ay1, input int ax2, input int ay2);
    return (ax1 - ax0) * (ay2 - ay0) - (ax2 - ax0) * (ay1 - ay0);
  endfunction

  function automatic int det_as_int(input logic [12:0] d);
    return int'($signed(d));
  endfunction

  task automatic drive(input int ax0, input int ay0, input int ax1,
                       input int ay1, input int ax2, input int ay2);
    x0 = 6'(ax0); y0 = 6'(ay0);
    x1 = 6'(ax1); y1 = 6'(ay1);
    x2 = 6'(ax2); y2 = 6'(ay2);
  endtask

  task automatic scramble();
    drive($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
          $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
  endtask

  // Present a triple, wait for the accept edge; returns with in_valid low, #1 after that edge.
  task automatic accept(input string tag, input int ax0, input int ay0, input int ax1,
                        input int ay1, input int ax2, input int ay2);
    int n;
    drive(ax0, ay0, ax1, ay1, ax2, ay2);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  // Count edges from the accept edge to the one that raises out_valid.
  task automatic wait_result(input string tag, output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check({tag, "_result_timeout"}, 0, 1);
  endtask

  task automatic run_triple(input string tag, input int ax0, input int ay0, input int ax1,
                            input int ay1, input int ax2, input int ay2);
    int lat;
    int exp;
    exp = ref_det(ax0, ay0, ax1, ay1, ax2, ay2);
    out_ready = 1'b1;
    accept(tag, ax0, ay0, ax1, ay1, ax2, ay2);
    wait_result(tag, lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_det"}, det_as_int(determinant), exp);
    check({tag, "_degen"}, int'(degenerate), int'(exp == 0));
    @(posedge clk); #1;
    check({tag, "_drop_valid"}, int'(out_valid), 0);
    check({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_det", int'(determinant), 0);
    check("rst_degen", int'(degenerate), 0);
    reset = 1'b0;

    run_triple("ccw", 0, 0, 10, 0, 0, 10);
    check("ccw_raw", int'(determinant), 'h0064);
    run_triple("cw", 0, 0, 0, 10, 10, 0);
    check("cw_raw", int'(determinant), 'h1F9C);
    run_triple("collinear", 0, 0, 5, 5, 10, 10);
    run_triple("coincident", 7, 7, 7, 7, 7, 7);
    run_triple("ext_pos", 0, 0, 63, 0, 0, 47);
    check("ext_pos_raw", int'(determinant), 'h0B91);
    run_triple("ext_neg", 0, 0, 0, 47, 63, 0);
    check("ext_neg_raw", int'(determinant), 'h146F);
    run_triple("ext_max", 0, 0, 63, 0, 0, 63);
    run_triple("ext_min", 0, 0, 0, 63, 63, 0);

    for (int i = 0; i < 40; i++) begin
      run_triple("rand", $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
                 $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
    end

    out_ready = 1'b0;
    accept("bp", 0, 0, 10, 0, 0, 10);
    wait_result("bp", lat);
    check("bp_latency", lat, 4);
    drive(0, 0, 0, 10, 10, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_det", det_as_int(determinant), 100);
      check("bp_hold_degen", int'(degenerate), 0);
      check("bp_hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    check("bp_second_taken", int'(in_ready), 0);
    in_valid = 1'b0;
    scramble();
    wait_result("bp2", lat);
    check("bp2_latency", lat, 4);
    check("bp2_det", det_as_int(determinant), -100);
    @(posedge clk); #1;

    for (int s = 1; s <= 4; s++) begin
      out_ready = 1'b0;
      accept("rst_mid", 0, 0, 10, 0, 0, 10);
      for (int k = 1; k < s; k++) begin
        @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_mid_in_ready", int'(in_ready), 1);
      check("rst_mid_out_valid", int'(out_valid), 0);
      check("rst_mid_det", int'(determinant), 0);
      @(posedge clk); #1;
      check("rst_mid_no_emit", int'(out_valid), 0);
      run_triple("post_rst", 0, 0, 63, 0, 0, 47);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed 1 expected 0");
    $fatal(1);
  end

endmodule
